// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-port memory between fetch and data
//                    accesses, with DM priority and an IF starvation guard.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              we_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              owner_q;

    logic              elig_if;
    logic              grant_any;
    logic              grant_dm;

    // DM wins every contested cycle unless IF has already lost STARVE_MAX in a row.
    always_comb begin
        elig_if   = if_req & ~halt;
        grant_any = elig_if | dm_req;
        grant_dm  = dm_req & ~(elig_if & (starve_q == STARVE_LIM));
        starve_d  = starve_q;
        if (grant_dm && elig_if) begin
            if (starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end else if (grant_any && !grant_dm) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            we_q        <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        owner_q    <= grant_dm;
                        starve_q   <= starve_d;
                        mem_addr_q <= grant_dm ? dm_addr : if_addr;
                        we_q       <= grant_dm & dm_we;
                        mem_re_q   <= ~(grant_dm & dm_we);
                        mem_we_q   <= grant_dm & dm_we;
                        if (grant_dm) begin
                            mem_wdata_q <= dm_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt_q    <= LAT_INIT;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= RESP;
                        if (owner_q) begin
                            dm_done_q <= 1'b1;
                            // Store completions leave the last loaded word in place.
                            if (!we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed bench for mem_port_arbiter (MEM_LAT 1 and 2).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req, dm_req, dm_we, halt;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_done, dm_done, mem_re, mem_we, busy, owner;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_dm_req, b_dm_we;
    logic [31:0] b_dm_addr, b_dm_wdata;
    logic        b_if_done, b_dm_done, b_mem_re, b_mem_we, b_busy, b_owner;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] b_pipe;
    logic [31:0] b_mem [0:255];

    int n_tests;
    int n_fail;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .halt(halt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .if_done(b_if_done), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_done(b_dm_done), .dm_rdata(b_dm_rdata), .halt(1'b0),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only memory for the MEM_LAT=1 instance: fixed content pattern.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
    endfunction

    always @(posedge clk) begin
        mem_rdata <= mem_re ? pat(mem_addr) : 32'h0;
    end

    // Read/write memory with two-cycle read latency for the MEM_LAT=2 instance.
    always @(posedge clk) begin
        if (b_mem_we) b_mem[b_mem_addr[9:2]] <= b_mem_wdata;
        b_pipe      <= b_mem_re ? b_mem[b_mem_addr[9:2]] : 32'h0;
        b_mem_rdata <= b_pipe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; halt = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b1; halt = 1'b0;
        dm_addr = 32'h80; dm_wdata = 32'h1;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        tick();
        tick();
        n_tests++;
        if ({if_done, dm_done, mem_re, mem_we, busy, owner} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {if_done, dm_done, mem_re, mem_we, busy, owner});
        end
        n_tests++;
        if (mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr);
        end
        n_tests++;
        if ({if_rdata, dm_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata});
        end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        n_tests++;
        if ({mem_re, mem_we, busy, owner} !== 4'b1010 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL fetch_issue: got re/we/busy/own=%b addr=%h want 1010 addr=00000040",
                     {mem_re, mem_we, busy, owner}, mem_addr);
        end
        tick();
        n_tests++;
        if (mem_re !== 1'b0 || if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait: got re=%b done=%b want 0 0", mem_re, if_done);
        end
        tick();
        n_tests++;
        if (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_done: got if_done=%b dm_done=%b rdata=%h want 1 0 deadbeef",
                     if_done, dm_done, if_rdata);
        end
        if_req = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || if_done !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_after: got busy=%b done=%b rdata=%h want 0 0 deadbeef",
                     busy, if_done, if_rdata);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        b_dm_req = 1'b1; b_dm_we = 1'b1; b_dm_addr = 32'h100; b_dm_wdata = 32'h12345678;
        tick();
        n_tests++;
        if (b_mem_we !== 1'b1 || b_mem_re !== 1'b0 || b_mem_addr !== 32'h100 || b_mem_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL store_issue: got we=%b re=%b addr=%h wdata=%h want 1 0 00000100 12345678",
                     b_mem_we, b_mem_re, b_mem_addr, b_mem_wdata);
        end
        tick();
        n_tests++;
        if (b_mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL store_we_width: got we=%b want 0", b_mem_we);
        end
        tick();
        n_tests++;
        if (b_dm_done !== 1'b0) begin
            n_fail++;
            $display("FAIL store_early_done: got %b want 0", b_dm_done);
        end
        tick();
        n_tests++;
        if (b_dm_done !== 1'b1 || b_dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_done: got done=%b rdata=%h want 1 00000000", b_dm_done, b_dm_rdata);
        end
        tick();
        b_dm_we = 1'b0;
        tick();
        n_tests++;
        if (b_mem_re !== 1'b1 || b_mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL load_issue: got re=%b addr=%h want 1 00000100", b_mem_re, b_mem_addr);
        end
        tick(); tick(); tick();
        n_tests++;
        if (b_dm_done !== 1'b1 || b_dm_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load_done: got done=%b rdata=%h want 1 12345678", b_dm_done, b_dm_rdata);
        end
        b_dm_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic exp_own [5];
        bit   found;
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int g = 0; g < 5; g++) begin
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                tick();
                if (mem_re === 1'b1) found = 1'b1;
            end
            n_tests++;
            if (!found || owner !== exp_own[g]) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got found=%b owner=%b want 1 %b",
                         g, found, owner, exp_own[g]);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_halt();
        int idle_bad;
        do_reset();
        idle_bad = 0;
        halt = 1'b1; if_req = 1'b1; if_addr = 32'h44;
        repeat (3) begin
            tick();
            if (busy !== 1'b0 || mem_re !== 1'b0) idle_bad++;
        end
        n_tests++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL halt_blocks_if: got %0d busy cycles want 0", idle_bad);
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        tick();
        n_tests++;
        if (mem_re !== 1'b1 || owner !== 1'b1 || mem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL halt_dm_issue: got re=%b owner=%b addr=%h want 1 1 00000080",
                     mem_re, owner, mem_addr);
        end
        tick(); tick();
        n_tests++;
        if (dm_done !== 1'b1 || if_done !== 1'b0 || dm_rdata !== 32'h5A5A0080) begin
            n_fail++;
            $display("FAIL halt_dm_done: got dm=%b if=%b rdata=%h want 1 0 5a5a0080",
                     dm_done, if_done, dm_rdata);
        end
        tick();
        dm_req = 1'b0; halt = 1'b0;
        tick();
        n_tests++;
        if (mem_re !== 1'b1 || owner !== 1'b0 || mem_addr !== 32'h44) begin
            n_fail++;
            $display("FAIL unhalt_if_issue: got re=%b owner=%b addr=%h want 1 0 00000044",
                     mem_re, owner, mem_addr);
        end
        tick(); tick();
        n_tests++;
        if (if_done !== 1'b1 || if_rdata !== 32'h5A5A0044 || dm_rdata !== 32'h5A5A0080) begin
            n_fail++;
            $display("FAIL unhalt_if_done: got done=%b if_rdata=%h dm_rdata=%h want 1 5a5a0044 5a5a0080",
                     if_done, if_rdata, dm_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, mem_re, mem_we, owner, if_done, dm_done} !== 6'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ctrl=%b addr=%h want 000000 00000000",
                     {busy, mem_re, mem_we, owner, if_done, dm_done}, mem_addr);
        end
        tick(); tick();
        n_tests++;
        if (if_done !== 1'b0 || dm_done !== 1'b0 || if_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got done=%b rdata=%h want 0 00000000", if_done, if_rdata);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (mem_re !== 1'b1 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL reset_mid_refetch_issue: got re=%b addr=%h want 1 00000040", mem_re, mem_addr);
        end
        tick(); tick();
        n_tests++;
        if (if_done !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL reset_mid_refetch_done: got done=%b rdata=%h want 1 deadbeef", if_done, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit found;
        int gap;
        do_reset();
        if_req = 1'b1; if_addr = 32'h48;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mem_re === 1'b1) found = 1'b1;
        end
        gap = 0;
        if (found) begin
            found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                tick();
                gap++;
                if (mem_re === 1'b1) found = 1'b1;
            end
        end
        n_tests++;
        if (!found || gap != 4) begin
            n_fail++;
            $display("FAIL back_to_back_gap: got found=%b gap=%0d want 1 4", found, gap);
        end
        if_req = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (busy !== 1'b0 || if_rdata !== 32'h5A5A0048) begin
            n_fail++;
            $display("FAIL back_to_back_end: got busy=%b rdata=%h want 0 5a5a0048", busy, if_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
